uart_ram_writer: RTL and testbench
==================================

Name: uart_ram_writer

Overview:
Host-to-device counterpart of the PUF readout path. Waits for the write command byte from the UART receiver and receives NUM_BYTES payload bytes. Packs each byte pair little-endian into 16-bit words and writes them into combined_ram through its write port, then reports ACK or NAK over the UART transmitter. Used to preload or overwrite SRAM contents for readout tests and helper-data storage.

Parameters:
NUM_BYTES, 16384, payload length in bytes; must be even, at most 16384
ADDR_W, 13, RAM word-address width
TIMEOUT_CYCLES, 12000000, maximum idle clk cycles allowed between payload bytes (1 s at 12 MHz)
CMD_WRITE, 8'h77, command byte 'w' that starts a transfer
ACK_BYTE, 8'h6B, 'k', sent after a complete transfer
NAK_BYTE, 8'h6E, 'n', sent after a timeout abort

Ports:
clk  in  1  system clock
rst  in  1  reset, asynchronous, active-high
uart_rx_ready  in  1  one-cycle pulse; uart_data_from_rx is valid in that cycle
uart_data_from_rx  in  8  received byte
uart_tx_ready  in  1  transmitter idle and able to accept a byte
uart_data_to_tx  out  8  byte to transmit; held stable until the transmission completes
uart_tx_enable  out  1  one-cycle send strobe
ram_waddr  out  ADDR_W  RAM word write address
ram_wdata  out  16  RAM write data
ram_we  out  1  RAM write enable, one-cycle pulse per word
ram_wmask  out  16  tied to 0 (all 16 bits written)
busy  out  1  high in every state except IDLE
done  out  1  one-cycle pulse when the ACK or NAK byte has finished sending

Behaviour:
- Reset (async): state=IDLE, byte index=0, timeout counter=0. All outputs 0: ram_we, uart_tx_enable, done, busy, ram_waddr, ram_wdata, uart_data_to_tx.
- States: IDLE, RECV_LO, RECV_HI, WRITE, SEND_RESP, WAIT_TX.
- IDLE:
  - rx pulse with data==CMD_WRITE -> RECV_LO; clear the byte index and the timeout counter.
  - Any other byte is ignored.
- RECV_LO: on an rx pulse, latch the byte into wdata[7:0] and go to RECV_HI.
- RECV_HI: on an rx pulse, latch the byte into wdata[15:8] and go to WRITE.
- WRITE:
  - Exactly one cycle. ram_we=1, ram_waddr = byte_index>>1 (the index of the low byte of the word).
  - Byte index advances by 2.
  - If the index reaches NUM_BYTES: select ACK_BYTE and go to SEND_RESP.
  - Otherwise go to RECV_LO.
  - An rx pulse arriving in the WRITE cycle is latched as the next low byte and the FSM goes directly to RECV_HI. Back-to-back bytes are never dropped.
- Byte order matches the readout path: even byte index -> bits [7:0], odd -> [15:8]. Word n = bytes 2n (LSB) and 2n+1 (MSB).
- Timeout:
  - In RECV_LO and RECV_HI the counter increments each cycle and clears on every rx pulse.
  - When it reaches TIMEOUT_CYCLES: select NAK_BYTE and go to SEND_RESP.
  - A latched but incomplete word is discarded. Words already written remain in RAM; no rollback.
- SEND_RESP: wait for uart_tx_ready=1, then assert uart_tx_enable for exactly 1 cycle and go to WAIT_TX. uart_data_to_tx is registered and stable from SEND_RESP entry until the next response.
- WAIT_TX:
  - Ignore uart_tx_ready in the first cycle (transmitter latency).
  - From then on, uart_tx_ready=1 -> pulse done and go to IDLE.
- rx pulses in SEND_RESP and WAIT_TX are ignored. A 'w' there does not start a transfer.
- Reset mid-transfer: ram_we drops immediately and the transfer is abandoned. A new 'w' restarts at word 0.
- ram_we is never high outside WRITE. uart_tx_enable is never high outside SEND_RESP.

Decomposition:
- Shared package puf_pkg: state encoding localparams, CMD_WRITE/ACK_BYTE/NAK_BYTE, the 's' read command, PUF_BYTES=16384. The reader and the writer use the same constants.
- One sub-module: rx_timeout_counter.
  - Inputs: clk, rst, enable, clear.
  - Output: expired.
  - Parameter: TIMEOUT_CYCLES.
  - Counter is 24 bits wide and saturates at expiry.

Test Plan:
- Reset asserted mid-cycle -> all outputs 0 asynchronously; busy=0.
- NUM_BYTES=4: send 'w',11,22,33,44 -> writes addr0=16'h2211 and addr1=16'h4433, one ram_we cycle each; then tx strobe with data 8'h6B, then a done pulse.
- Noise in IDLE: send 'x','s',8'h00 -> no ram_we, no tx strobe, busy stays 0.
- TIMEOUT_CYCLES=100, NUM_BYTES=4: send 'w',AA,BB,CC, then silence -> one write addr0=16'hBBAA; 100 cycles after CC, tx data 8'h6E; no second write.
- rx pulse arriving in the WRITE cycle (payload 01,02 then 03 on the WRITE cycle, then 04) -> addr0=16'h0201, addr1=16'h0403; ACK sent.
- Hold uart_tx_ready=0 at completion for 50 cycles -> uart_tx_enable stays 0 until ready rises, then a single 1-cycle strobe. Separately: rst after 3 bytes, then a full 'w'+4-byte transfer -> writes start at addr0.

Source files
------------

// File: rtl/puf_pkg.sv
// Shared constants and state encoding for the PUF UART readout/writer paths.
// Holds the command/response bytes, the payload length and the writer FSM states.
package puf_pkg;

  localparam int unsigned PUF_BYTES = 16384;
  localparam int unsigned TIMEOUT_W = 24;

  localparam logic [7:0] CMD_READ  = 8'h73;  // 's'
  localparam logic [7:0] CMD_WRITE = 8'h77;  // 'w'
  localparam logic [7:0] ACK_BYTE  = 8'h6B;  // 'k'
  localparam logic [7:0] NAK_BYTE  = 8'h6E;  // 'n'

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_RECV_LO   = 3'd1,
    S_RECV_HI   = 3'd2,
    S_WRITE     = 3'd3,
    S_SEND_RESP = 3'd4,
    S_WAIT_TX   = 3'd5
  } wr_state_e;

endpackage

// File: rtl/rx_timeout_counter.sv
// Inter-byte idle counter. Counts enabled cycles, clears on request and
// saturates at TIMEOUT_CYCLES, where expired stays high until cleared.
// Ports: clk, rst (async, active-high), enable, clear -> expired (registered).
module rx_timeout_counter
  import puf_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 12000000
) (
  input  logic clk,
  input  logic rst,
  input  logic enable,
  input  logic clear,
  output logic expired
);

  localparam logic [TIMEOUT_W-1:0] LIMIT = TIMEOUT_W'(TIMEOUT_CYCLES);

  logic [TIMEOUT_W-1:0] count;
  logic [TIMEOUT_W-1:0] count_next;

  // Clear wins over counting; counting stops at the limit.
  always_comb begin
    count_next = count;
    if (clear) begin
      count_next = '0;
    end else if (enable && (count != LIMIT)) begin
      count_next = count + TIMEOUT_W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count   <= '0;
      expired <= 1'b0;
    end else begin
      count   <= count_next;
      expired <= (count_next == LIMIT);
    end
  end

endmodule

// File: rtl/uart_ram_writer.sv
// Receives a 'w' command plus NUM_BYTES payload bytes from the UART, packs byte
// pairs little-endian into 16-bit words, writes them to combined_ram and answers
// with ACK, or NAK if the host goes silent for TIMEOUT_CYCLES mid-transfer.
// Ports: clk, rst (async, active-high); uart_rx_ready/uart_data_from_rx (rx
// byte strobe); uart_tx_ready, uart_data_to_tx, uart_tx_enable (response);
// ram_waddr/ram_wdata/ram_we/ram_wmask (RAM write port); busy, done (status).
module uart_ram_writer #(
  parameter int unsigned NUM_BYTES      = puf_pkg::PUF_BYTES,
  parameter int unsigned ADDR_W         = 13,
  parameter int unsigned TIMEOUT_CYCLES = 12000000,
  parameter logic [7:0]  CMD_WRITE      = puf_pkg::CMD_WRITE,
  parameter logic [7:0]  ACK_BYTE       = puf_pkg::ACK_BYTE,
  parameter logic [7:0]  NAK_BYTE       = puf_pkg::NAK_BYTE
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              uart_rx_ready,
  input  logic [7:0]        uart_data_from_rx,
  input  logic              uart_tx_ready,
  output logic [7:0]        uart_data_to_tx,
  output logic              uart_tx_enable,
  output logic [ADDR_W-1:0] ram_waddr,
  output logic [15:0]       ram_wdata,
  output logic              ram_we,
  output logic [15:0]       ram_wmask,
  output logic              busy,
  output logic              done
);

  // One extra bit so the index can hold NUM_BYTES itself.
  localparam int unsigned      IDX_W   = $clog2(NUM_BYTES) + 1;
  localparam logic [IDX_W-1:0] IDX_END = IDX_W'(NUM_BYTES);

  puf_pkg::wr_state_e state;
  puf_pkg::wr_state_e state_next;

  logic [IDX_W-1:0]  idx;
  logic [IDX_W-1:0]  idx_next;
  logic [IDX_W-1:0]  idx_adv;
  logic [15:0]       wdata_next;
  logic [ADDR_W-1:0] waddr_next;
  logic [7:0]        tx_data_next;
  logic              we_next;
  logic              tx_en_next;
  logic              done_next;
  logic              busy_next;
  logic              first_wait;
  logic              first_wait_next;
  logic              recv_phase;
  logic              rx_expired;

  assign ram_wmask  = '0;
  assign recv_phase = (state == puf_pkg::S_RECV_LO) || (state == puf_pkg::S_RECV_HI);

  // Idle timer only runs while waiting for payload; every received byte restarts it.
  rx_timeout_counter #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_rx_timeout (
    .clk    (clk),
    .rst    (rst),
    .enable (recv_phase),
    .clear  (uart_rx_ready || !recv_phase),
    .expired(rx_expired)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= puf_pkg::S_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next state plus next values of every registered output.
  always_comb begin
    state_next      = state;
    idx_next        = idx;
    wdata_next      = ram_wdata;
    waddr_next      = ram_waddr;
    tx_data_next    = uart_data_to_tx;
    we_next         = 1'b0;
    tx_en_next      = 1'b0;
    done_next       = 1'b0;
    first_wait_next = 1'b0;
    idx_adv         = idx + IDX_W'(2);

    unique case (state)
      puf_pkg::S_IDLE: begin
        if (uart_rx_ready && (uart_data_from_rx == CMD_WRITE)) begin
          idx_next   = '0;
          state_next = puf_pkg::S_RECV_LO;
        end
      end

      puf_pkg::S_RECV_LO: begin
        if (uart_rx_ready) begin
          wdata_next[7:0] = uart_data_from_rx;
          state_next      = puf_pkg::S_RECV_HI;
        end else if (rx_expired) begin
          tx_data_next = NAK_BYTE;
          state_next   = puf_pkg::S_SEND_RESP;
        end
      end

      // The write strobe and address are registered on entry to WRITE.
      puf_pkg::S_RECV_HI: begin
        if (uart_rx_ready) begin
          wdata_next[15:8] = uart_data_from_rx;
          we_next          = 1'b1;
          waddr_next       = ADDR_W'(idx >> 1);
          state_next       = puf_pkg::S_WRITE;
        end else if (rx_expired) begin
          tx_data_next = NAK_BYTE;
          state_next   = puf_pkg::S_SEND_RESP;
        end
      end

      // A byte arriving during the write cycle is the next low byte.
      puf_pkg::S_WRITE: begin
        idx_next = idx_adv;
        if (idx_adv == IDX_END) begin
          tx_data_next = ACK_BYTE;
          state_next   = puf_pkg::S_SEND_RESP;
        end else if (uart_rx_ready) begin
          wdata_next[7:0] = uart_data_from_rx;
          state_next      = puf_pkg::S_RECV_HI;
        end else begin
          state_next = puf_pkg::S_RECV_LO;
        end
      end

      // Strobe is raised for one cycle while still in SEND_RESP, then we move on.
      puf_pkg::S_SEND_RESP: begin
        if (uart_tx_enable) begin
          first_wait_next = 1'b1;
          state_next      = puf_pkg::S_WAIT_TX;
        end else if (uart_tx_ready) begin
          tx_en_next = 1'b1;
        end
      end

      // Transmitter ready is stale in the first cycle after the strobe.
      puf_pkg::S_WAIT_TX: begin
        if (!first_wait && uart_tx_ready) begin
          done_next  = 1'b1;
          state_next = puf_pkg::S_IDLE;
        end
      end

      default: state_next = puf_pkg::S_IDLE;
    endcase

    busy_next = (state_next != puf_pkg::S_IDLE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      idx             <= '0;
      ram_wdata       <= '0;
      ram_waddr       <= '0;
      ram_we          <= 1'b0;
      uart_data_to_tx <= '0;
      uart_tx_enable  <= 1'b0;
      done            <= 1'b0;
      busy            <= 1'b0;
      first_wait      <= 1'b0;
    end else begin
      idx             <= idx_next;
      ram_wdata       <= wdata_next;
      ram_waddr       <= waddr_next;
      ram_we          <= we_next;
      uart_data_to_tx <= tx_data_next;
      uart_tx_enable  <= tx_en_next;
      done            <= done_next;
      busy            <= busy_next;
      first_wait      <= first_wait_next;
    end
  end

endmodule

// File: tb/tb_uart_ram_writer.sv
// Scoreboard bench for uart_ram_writer: stimulus pushes expected RAM writes and
// response bytes into queues, a monitor pops and compares on ram_we / tx strobes.
module tb_uart_ram_writer;

  localparam int unsigned NB     = 4;
  localparam int unsigned AW     = 13;
  localparam int unsigned TMO    = 100;
  localparam logic [7:0]  CMD_W  = 8'h77;
  localparam logic [7:0]  ACK_B  = 8'h6B;
  localparam logic [7:0]  NAK_B  = 8'h6E;

  typedef struct {
    logic [AW-1:0] addr;
    logic [15:0]   data;
  } wr_t;

  typedef struct {
    logic [7:0] b;
    int         lo;
    int         hi;
  } tx_t;

  logic          clk;
  logic          rst;
  logic          uart_rx_ready;
  logic [7:0]    uart_data_from_rx;
  logic          uart_tx_ready;
  logic [7:0]    uart_data_to_tx;
  logic          uart_tx_enable;
  logic [AW-1:0] ram_waddr;
  logic [15:0]   ram_wdata;
  logic          ram_we;
  logic [15:0]   ram_wmask;
  logic          busy;
  logic          done;

  wr_t        exp_wr_q[$];
  tx_t        exp_tx_q[$];
  logic [7:0] pay[$];

  int n_cmp = 0;
  int n_err = 0;
  int cyc = 0;
  int n_resp = 0;
  int done_cnt = 0;
  bit hold = 0;
  int tx_busy = 0;

  uart_ram_writer #(
    .NUM_BYTES     (NB),
    .ADDR_W        (AW),
    .TIMEOUT_CYCLES(TMO)
  ) dut (
    .clk              (clk),
    .rst              (rst),
    .uart_rx_ready    (uart_rx_ready),
    .uart_data_from_rx(uart_data_from_rx),
    .uart_tx_ready    (uart_tx_ready),
    .uart_data_to_tx  (uart_data_to_tx),
    .uart_tx_enable   (uart_tx_enable),
    .ram_waddr        (ram_waddr),
    .ram_wdata        (ram_wdata),
    .ram_we           (ram_we),
    .ram_wmask        (ram_wmask),
    .busy             (busy),
    .done             (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Transmitter model: goes busy for a while after each strobe; hold forces it not ready.
  initial begin
    uart_tx_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      if (uart_tx_enable) tx_busy = 12;
      else if (tx_busy > 0) tx_busy--;
      uart_tx_ready = (tx_busy == 0) && !hold;
    end
  end

  // Monitor: compare every RAM write and every response strobe against the queues.
  initial begin
    bit  prev_we = 0;
    bit  prev_en = 0;
    wr_t ew;
    tx_t et;
    forever begin
      @(negedge clk);
      if (!rst) begin
        if (ram_we) begin
          check("we_single_cycle", 32'(prev_we), 32'd0);
          check("wmask", 32'(ram_wmask), 32'd0);
          if (exp_wr_q.size() == 0) begin
            n_cmp++;
            n_err++;
            $display("FAIL unexpected_write: got addr %0h data %0h, none required", ram_waddr, ram_wdata);
          end else begin
            ew = exp_wr_q.pop_front();
            check("wr_addr", 32'(ram_waddr), 32'(ew.addr));
            check("wr_data", 32'(ram_wdata), 32'(ew.data));
          end
        end
        if (uart_tx_enable) begin
          check("tx_strobe_single", 32'(prev_en), 32'd0);
          check("tx_while_not_ready", 32'(hold), 32'd0);
          if (exp_tx_q.size() == 0) begin
            n_cmp++;
            n_err++;
            $display("FAIL unexpected_tx: got byte %0h, none required", uart_data_to_tx);
          end else begin
            et = exp_tx_q.pop_front();
            check("tx_byte", 32'(uart_data_to_tx), 32'(et.b));
            check("tx_in_window", 32'((cyc >= et.lo) && (cyc <= et.hi)), 32'd1);
          end
        end
        if (done) done_cnt++;
        prev_we = ram_we;
        prev_en = uart_tx_enable;
      end else begin
        prev_we = 0;
        prev_en = 0;
      end
    end
  end

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send_byte(input logic [7:0] b);
    uart_rx_ready     = 1'b1;
    uart_data_from_rx = b;
    @(posedge clk);
    #1;
    uart_rx_ready = 1'b0;
  endtask

  function automatic int pick_gap(input int mode);
    if (mode == 1) return 2;
    if (mode == 2) return 0;
    return ($urandom_range(0, 2) == 0) ? 0 : int'($urandom_range(1, 8));
  endfunction

  task automatic wait_idle();
    int t = 0;
    while (busy && t < 2000) begin
      @(posedge clk);
      #1;
      t++;
    end
    if (busy) begin
      n_cmp++;
      n_err++;
      $display("FAIL wait_idle: still busy after %0d cycles", t);
    end
  endtask

  // kind 0: full transfer, 1: stop after pay.size() bytes (timeout), 2: full with tx held off.
  task automatic run_xfer(input int kind, input int gap_mode);
    int k;
    int last;
    k = pay.size();
    for (int n = 0; n < k / 2; n++)
      exp_wr_q.push_back('{addr: AW'(n), data: {pay[2*n+1], pay[2*n]}});
    if (kind == 2) hold = 1;
    idle(pick_gap(gap_mode));
    send_byte(CMD_W);
    check("busy_after_cmd", 32'(busy), 32'd1);
    for (int i = 0; i < k; i++) begin
      idle(pick_gap(gap_mode));
      send_byte(pay[i]);
    end
    last = cyc;
    if (kind == 1) exp_tx_q.push_back('{b: NAK_B, lo: last + TMO - 2, hi: last + TMO + 6});
    else           exp_tx_q.push_back('{b: ACK_B, lo: last, hi: last + 200});
    n_resp++;
    if (kind == 2) begin
      // A 'w' and random noise while the response is pending must be ignored.
      send_byte(CMD_W);
      for (int i = 0; i < 4; i++) begin
        idle(3);
        send_byte(8'($urandom_range(0, 255)));
      end
      idle(50);
      hold = 0;
    end
    wait_idle();
    check("busy_after_xfer", 32'(busy), 32'd0);
    idle(3);
  endtask

  task automatic fill_random(input int k);
    pay.delete();
    for (int i = 0; i < k; i++) pay.push_back(8'($urandom_range(0, 255)));
  endtask

  task automatic summary();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
  endtask

  initial begin
    #1_000_000;
    n_err++;
    $display("FAIL watchdog: simulation did not finish in time");
    summary();
    $fatal(1, "watchdog");
  end

  initial begin
    int r;
    rst               = 1'b1;
    uart_rx_ready     = 1'b0;
    uart_data_from_rx = 8'h00;
    #12;
    check("rst_ctrl", {28'd0, ram_we, uart_tx_enable, done, busy}, 32'd0);
    check("rst_data", {3'd0, ram_waddr, ram_wdata}, 32'd0);
    check("rst_txdata", 32'(uart_data_to_tx), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;

    // Non-command bytes in IDLE are ignored.
    send_byte(8'h78);
    check("noise_busy_x", 32'(busy), 32'd0);
    send_byte(8'h73);
    check("noise_busy_s", 32'(busy), 32'd0);
    send_byte(8'h00);
    check("noise_busy_0", 32'(busy), 32'd0);
    for (int i = 0; i < 6; i++) begin
      do r = int'($urandom_range(0, 255)); while (r == int'(CMD_W));
      idle(pick_gap(0));
      send_byte(8'(r));
      check("noise_busy_rand", 32'(busy), 32'd0);
    end
    idle(5);

    pay = '{8'h11, 8'h22, 8'h33, 8'h44};
    run_xfer(0, 1);

    pay = '{8'hAA, 8'hBB, 8'hCC};
    run_xfer(1, 1);

    pay = '{8'h01, 8'h02, 8'h03, 8'h04};
    run_xfer(0, 2);

    fill_random(NB);
    run_xfer(2, 0);

    // Reset during the WRITE cycle: the strobe must drop at once, nothing is written.
    send_byte(CMD_W);
    send_byte(8'h5A);
    send_byte(8'hA5);
    check("we_before_rst", 32'(ram_we), 32'd1);
    #2;
    rst = 1'b1;
    #1;
    check("midrst_ctrl", {28'd0, ram_we, uart_tx_enable, done, busy}, 32'd0);
    check("midrst_data", {3'd0, ram_waddr, ram_wdata}, 32'd0);
    check("midrst_txdata", 32'(uart_data_to_tx), 32'd0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    fill_random(NB);
    run_xfer(0, 0);

    for (int it = 0; it < 16; it++) begin
      r = int'($urandom_range(0, 3));
      if (r == 2) begin
        fill_random(int'($urandom_range(0, NB - 1)));
        run_xfer(1, 0);
      end else if (r == 3) begin
        fill_random(NB);
        run_xfer(2, 0);
      end else begin
        fill_random(NB);
        run_xfer(0, int'($urandom_range(0, 2)));
      end
    end

    idle(20);
    check("wr_queue_empty", 32'(exp_wr_q.size()), 32'd0);
    check("tx_queue_empty", 32'(exp_tx_q.size()), 32'd0);
    check("done_count", 32'(done_cnt), 32'(n_resp));
    summary();
    $finish;
  end

endmodule
